// File: rtl/reg_in_unit.sv
// reg_in_unit: the host reads the external input buffers through this block.
//   Each raw pin passes through a 2-FF synchronizer. Each port then has a
//   debouncer that compares the whole port at once. A port raises a change flag
//   when a new value is accepted. Reads have a fixed 1-cycle latency. The IRQ
//   output is maskable per port.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   data_in_to_buf  raw pins, port p = [p*PORT_W +: PORT_W]
//   rd_req/rd_addr  read strobe and port index
//   clr_all         clear every change flag
//   irq_en          per-port interrupt enable
//   rd_valid        read result valid; rd_data = {chg, zeros, value}
//   chg_flags       live change flags
//   irq             registered OR of enabled change flags

// Per-port lane: synchronizer, debounce counter, accepted value, change flag.
module reg_in_port #(
  parameter int PORT_W     = 8,
  parameter int DEB_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PORT_W-1:0] pin_i,
  input  logic              clr_i,
  output logic [PORT_W-1:0] deb_val_o,
  output logic              chg_o
);
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [PORT_W-1:0] sync1_q, sync2_q, deb_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              chg_q;
  logic              differ, accept;

  assign differ = (sync2_q != deb_q);
  assign accept = differ && (cnt_q == CNT_W'(DEB_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      cnt_q   <= '0;
      chg_q   <= 1'b0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      // Any return to the accepted value restarts the persistence count.
      if (!differ) begin
        cnt_q <= '0;
      end else if (accept) begin
        deb_q <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      // A new event on the same edge beats any clear, so no event is lost.
      chg_q <= accept | (chg_q & ~clr_i);
    end
  end

  assign deb_val_o = deb_q;
  assign chg_o     = chg_q;
endmodule

module reg_in_unit #(
  parameter int NUM_PORTS  = 16,
  parameter int PORT_W     = 8,
  parameter int DEB_CYCLES = 4,
  parameter int ADDR_W     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS*PORT_W-1:0] data_in_to_buf,
  input  logic                        rd_req,
  input  logic [ADDR_W-1:0]           rd_addr,
  input  logic                        clr_all,
  input  logic [NUM_PORTS-1:0]        irq_en,
  output logic                        rd_valid,
  output logic [15:0]                 rd_data,
  output logic [NUM_PORTS-1:0]        chg_flags,
  output logic                        irq
);
  logic [NUM_PORTS-1:0][PORT_W-1:0] deb_val;
  logic [NUM_PORTS-1:0]             chg, clr_vec;
  logic [15:0]                      rd_word_d, rd_data_q;
  logic                             rd_valid_q, irq_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    // A read of port p clears its flag on the same edge that the read is accepted.
    assign clr_vec[p] = clr_all | (rd_req && (rd_addr == ADDR_W'(p)));

    reg_in_port #(
      .PORT_W     (PORT_W),
      .DEB_CYCLES (DEB_CYCLES)
    ) u_port (
      .clk       (clk),
      .rst_n     (rst_n),
      .pin_i     (data_in_to_buf[p*PORT_W +: PORT_W]),
      .clr_i     (clr_vec[p]),
      .deb_val_o (deb_val[p]),
      .chg_o     (chg[p])
    );
  end

  // Decode loop instead of indexing: an address with no matching port reads as zero.
  always_comb begin
    rd_word_d = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rd_addr == ADDR_W'(p)) begin
        rd_word_d[15]         = chg[p];
        rd_word_d[PORT_W-1:0] = deb_val[p];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      rd_valid_q <= rd_req;
      if (rd_req) rd_data_q <= rd_word_d;
      irq_q <= |(chg & irq_en);
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign chg_flags = chg;
  assign irq       = irq_q;
endmodule

// File: tb/tb_reg_in_unit.sv
// Self-checking bench for reg_in_unit (12 ports x 8 bits, debounce of 4).
// Expected read words are queued when a read is issued. A monitor pops them
// when rd_valid is seen.
module tb_reg_in_unit;
  localparam int NP = 12;
  localparam int PW = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NP*PW-1:0] pins;
  logic             rd_req;
  logic [3:0]       rd_addr;
  logic             clr_all;
  logic [NP-1:0]    irq_en;
  logic             rd_valid;
  logic [15:0]      rd_data;
  logic [NP-1:0]    chg_flags;
  logic             irq;

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] sb[$];

  reg_in_unit #(.NUM_PORTS(NP), .PORT_W(PW), .DEB_CYCLES(4), .ADDR_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in_to_buf (pins),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .clr_all        (clr_all),
    .irq_en         (irq_en),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .chg_flags      (chg_flags),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Inputs change 1ns after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_issue(input logic [3:0] a, input logic [15:0] exp);
    rd_req  = 1'b1;
    rd_addr = a;
    sb.push_back(exp);
    tick(1);
    rd_req  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      if (sb.size() == 0) chk("rd_unexpected", 32'(rd_valid), 32'd0);
      else chk("rd_data", 32'(rd_data), 32'(sb.pop_front()));
    end
  end

  initial begin
    logic [3:0]  addrs[5];
    logic [15:0] exps[5];
    rst_n = 1'b0; pins = '0; rd_req = 1'b0; rd_addr = '0; clr_all = 1'b0; irq_en = '0;
    #12;
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data",  32'(rd_data),  32'd0);
    chk("rst_irq",   32'(irq),      32'd0);
    chk("rst_chg",   32'(chg_flags), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // 1: idle read of port 3
    rd_issue(4'd3, 16'h0000);
    chk("t1_irq", 32'(irq), 32'd0);

    // 2: port 5 change is seen exactly 6 edges later
    pins[5*PW +: PW] = 8'hA5;
    tick(5);
    chk("t2_chg5_early", 32'(chg_flags[5]), 32'd0);
    tick(1);
    chk("t2_chg5", 32'(chg_flags[5]), 32'd1);
    rd_issue(4'd5, 16'h80A5);
    chk("t2_chg5_clr", 32'(chg_flags[5]), 32'd0);

    // 3: a 3-clock glitch is rejected; a held value is accepted
    pins[2*PW +: PW] = 8'h01;
    tick(3);
    pins[2*PW +: PW] = 8'h00;
    tick(8);
    chk("t3_glitch", 32'(chg_flags[2]), 32'd0);
    rd_issue(4'd2, 16'h0000);
    pins[2*PW +: PW] = 8'h01;
    tick(5);
    chk("t3_early", 32'(chg_flags[2]), 32'd0);
    tick(1);
    chk("t3_accept", 32'(chg_flags[2]), 32'd1);
    rd_issue(4'd2, 16'h8001);

    // 4: interrupt path, clears, and a set that coincides with a clear
    irq_en[7] = 1'b1;
    pins[7*PW +: PW] = 8'h3C;
    tick(6);
    chk("t4_chg7", 32'(chg_flags[7]), 32'd1);
    chk("t4_irq_lag", 32'(irq), 32'd0);
    tick(1);
    chk("t4_irq", 32'(irq), 32'd1);
    clr_all = 1'b1;
    tick(1);
    clr_all = 1'b0;
    chk("t4_clrall_chg", 32'(chg_flags[7]), 32'd0);
    chk("t4_clrall_irq_lag", 32'(irq), 32'd1);
    tick(1);
    chk("t4_clrall_irq", 32'(irq), 32'd0);
    pins[7*PW +: PW] = 8'hC3;
    tick(5);
    clr_all = 1'b1;
    tick(1);
    clr_all = 1'b0;
    chk("t4_set_wins", 32'(chg_flags[7]), 32'd1);
    tick(1);
    chk("t4_irq2", 32'(irq), 32'd1);
    irq_en[7] = 1'b0;
    tick(1);
    chk("t4_mask", 32'(irq), 32'd0);
    irq_en[7] = 1'b1;
    tick(1);
    chk("t4_unmask", 32'(irq), 32'd1);
    pins[4*PW +: PW] = 8'h11;
    tick(6);
    chk("t4_chg4", 32'(chg_flags[4]), 32'd1);
    pins[4*PW +: PW] = 8'h22;
    tick(5);
    rd_issue(4'd4, 16'h8011);
    chk("t4_rd_set_wins", 32'(chg_flags[4]), 32'd1);
    rd_issue(4'd4, 16'h8022);
    chk("t4_rd_clr", 32'(chg_flags[4]), 32'd0);

    // 5: back-to-back reads, including an unmapped address
    addrs[0] = 4'd0;  exps[0] = 16'h0000;
    addrs[1] = 4'd1;  exps[1] = 16'h0000;
    addrs[2] = 4'd2;  exps[2] = 16'h0001;
    addrs[3] = 4'd15; exps[3] = 16'h0000;
    addrs[4] = 4'd5;  exps[4] = 16'h00A5;
    rd_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd_addr = addrs[i];
      sb.push_back(exps[i]);
      tick(1);
      chk("t5_b2b_valid", 32'(rd_valid), 32'd1);
    end
    rd_req = 1'b0;
    tick(1);
    chk("t5_valid_drop", 32'(rd_valid), 32'd0);
    chk("t5_data_hold", 32'(rd_data), 32'h00A5);

    // 6: asynchronous reset in the middle of a debounce, then release with pins high
    pins[9*PW +: PW] = 8'h5A;
    tick(3);
    rd_issue(4'd9, 16'h0000);
    chk("t6_pre_valid", 32'(rd_valid), 32'd1);
    chk("t6_pre_irq", 32'(irq), 32'd1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(rd_valid), 32'd0);
    chk("t6_async_data", 32'(rd_data), 32'd0);
    chk("t6_async_irq", 32'(irq), 32'd0);
    chk("t6_async_chg", 32'(chg_flags), 32'd0);
    pins = '1;
    tick(1);
    rst_n = 1'b1;
    tick(5);
    chk("t6_post_early", 32'(chg_flags), 32'd0);
    tick(1);
    chk("t6_post_chg", 32'(chg_flags), 32'hFFF);
    tick(1);
    chk("t6_post_irq", 32'(irq), 32'd1);
    rd_issue(4'd9, 16'h80FF);
    tick(2);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
